// File: rtl/fifo_wr_arb_pkg.sv
// Shared constants for the FIFO write arbiter: FSM state encoding and grant indices.
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BEAT_LO = 2'b01,
    BEAT_HI = 2'b10
  } state_e;

  localparam logic GNT_REQ0 = 1'b0;
  localparam logic GNT_REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic with a last-grant pointer (round-robin on ties).
// Defining FIFO_WR_ARB_PRIO_EN selects fixed priority (requester 0 wins) and drops the pointer.
module rr_arb2
  import fifo_wr_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic vld0,
  input  logic vld1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  logic tie_to_1;

`ifdef FIFO_WR_ARB_PRIO_EN
  logic unused_prio;
  assign unused_prio = ^{clk, rst, accept};
  assign tie_to_1    = 1'b0;
`else
  logic last_q, last_d;
  logic gnt_idx;

  assign gnt_idx = gnt1 ? GNT_REQ1 : GNT_REQ0;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    last_d = last_q;
    if (accept) last_d = gnt_idx;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (rst) last_q <= GNT_REQ1;
    else     last_q <= last_d;
  end

  // While reset is held the stale pointer is ignored so requester 0 wins a tie.
  assign tie_to_1 = vld0 & vld1 & (last_q == GNT_REQ0) & ~rst;
`endif

  assign gnt1 = vld1 & (~vld0 | tie_to_1);
  assign gnt0 = vld0 & ~gnt1;

endmodule

// File: rtl/fifo_wr_arb.sv
// Arbitrates a 1- or 2-beat ALU word and a 1-beat register-file byte onto a FIFO write port.
// Tie policy is round-robin unless FIFO_WR_ARB_PRIO_EN is defined (fixed priority, see rr_arb2).
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VLD,
  input  logic                 REQ0_WIDE,
  input  logic [2*DATA_WD-1:0] REQ0_DATA,
  output logic                 REQ0_RDY,
  input  logic                 REQ1_VLD,
  input  logic [DATA_WD-1:0]   REQ1_DATA,
  output logic                 REQ1_RDY,
  input  logic                 FIFO_FULL,
  output logic                 WR_INC,
  output logic [DATA_WD-1:0]   WR_DATA,
  output logic                 BUSY
);

  state_e               state_q, state_d;
  logic [2*DATA_WD-1:0] hold_q, hold_d;
  logic                 wide_q, wide_d;
  logic                 gnt0, gnt1;
  logic                 in_idle, in_beat, accept;

  // Reset forces idle-looking outputs even while a stale beat state is still registered.
  assign in_idle = RST | (state_q == IDLE);
  assign in_beat = ~RST & ((state_q == BEAT_LO) | (state_q == BEAT_HI));
  assign accept  = ~RST & (state_q == IDLE) & (gnt0 | gnt1);

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst   (RST),
    .vld0  (REQ0_VLD),
    .vld1  (REQ1_VLD),
    .accept(accept),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign REQ0_RDY = in_idle & gnt0;
  assign REQ1_RDY = in_idle & gnt1;
  assign WR_INC   = in_beat & ~FIFO_FULL;
  assign BUSY     = ~RST & (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wide_d  = wide_q;
    WR_DATA = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BEAT_LO;
          hold_d  = gnt0 ? REQ0_DATA : {{DATA_WD{1'b0}}, REQ1_DATA};
          wide_d  = gnt0 & REQ0_WIDE;
        end
      end
      BEAT_LO: begin
        WR_DATA = hold_q[DATA_WD-1:0];
        if (WR_INC) state_d = wide_q ? BEAT_HI : IDLE;
      end
      BEAT_HI: begin
        WR_DATA = hold_q[2*DATA_WD-1:DATA_WD];
        if (WR_INC) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (RST) WR_DATA = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      wide_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wide_q  <= wide_d;
    end
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WD, default 8: width of one FIFO write beat.
REQ-002 SHALL have port CLK, input, 1: single clock; reset is synchronous and active-high.
REQ-003 SHALL have port RST, input, 1: synchronous active-high reset, sampled on rising CLK.
REQ-004 SHALL have port REQ0_VLD, input, 1: requester 0 (ALU result) has a word.
REQ-005 SHALL have port REQ0_WIDE, input, 1: requester 0 word is 2 beats when 1, and 1 beat (low half) when 0.
REQ-006 SHALL have port REQ0_DATA, input, 2*DATA_WD: requester 0 word.
REQ-007 SHALL have port REQ0_RDY, output, 1: requester 0 word accepted this cycle when high with REQ0_VLD.
REQ-008 SHALL have port REQ1_VLD, input, 1: requester 1 (register-file read) has a byte.
REQ-009 SHALL have port REQ1_DATA, input, DATA_WD: requester 1 byte.
REQ-010 SHALL have port REQ1_RDY, output, 1: requester 1 byte accepted this cycle when high with REQ1_VLD.
REQ-011 SHALL have port FIFO_FULL, input, 1: FIFO write-side full flag.
REQ-012 SHALL have port WR_INC, output, 1: FIFO write strobe.
REQ-013 SHALL have port WR_DATA, output, DATA_WD: FIFO write data.
REQ-014 SHALL have port BUSY, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL use FSM states IDLE, BEAT_LO and BEAT_HI.
REQ-016 SHALL assert REQx_RDY only in IDLE and only for the granted requester, so at most one RDY is high per cycle.
REQ-017 SHALL, on acceptance (VLD&RDY), capture the data into a 2*DATA_WD holding register and the width into a wide flag, and move to BEAT_LO.
REQ-018 SHALL drive WR_DATA from the holding register: low half in BEAT_LO, high half in BEAT_HI, and 0 in IDLE.
REQ-019 SHALL drive WR_INC = (state is BEAT_LO or BEAT_HI) & ~FIFO_FULL, combinationally.
REQ-020 SHALL transition BEAT_LO->BEAT_HI when WR_INC & wide, BEAT_LO->IDLE when WR_INC & ~wide, and BEAT_HI->IDLE when WR_INC; otherwise it holds state.
REQ-021 SHALL give a first-beat latency of 1 cycle after acceptance when FIFO_FULL=0; a narrow write occupies 2 cycles (accept + beat) and a wide write occupies 3.
REQ-022 SHALL stall on FIFO_FULL=1 with no beat lost or duplicated, and hold WR_DATA stable throughout the stall.
REQ-023 SHALL arbitrate round-robin when both VLD are high in IDLE: grant the requester not granted last; update the last-grant pointer only on acceptance.
REQ-024 SHALL grant a single VLD requester regardless of the pointer.
REQ-025 SHALL ignore REQ1 wide semantics; requester 1 is always a single beat, with the high half of the holding register set to 0.
REQ-026 SHALL treat VLD deassertion before acceptance as a legal withdrawal with no side effects.

Reset
REQ-027 SHALL, on RST=1 at the rising CLK edge, set state to IDLE, clear the holding register and wide flag, and set the last-grant pointer to 1 (requester 0 wins the first tie).
REQ-028 SHALL drive the following while RST=1 and in the first cycle after reset: WR_INC=0, WR_DATA=0, BUSY=0, REQ0_RDY=REQ0_VLD, REQ1_RDY=REQ1_VLD&~REQ0_VLD.
REQ-029 SHALL abandon any in-flight beat on a mid-transfer reset; a partially written wide word is not completed.

Configuration
REQ-030 SHALL, with FIFO_WR_ARB_PRIO_EN defined, use fixed priority: requester 0 always wins a tie, and the last-grant pointer is not implemented.
REQ-031 SHALL, without FIFO_WR_ARB_PRIO_EN, use round-robin per REQ-023.

Structure
REQ-032 SHALL place the state encoding constants (IDLE=2'b00, BEAT_LO=2'b01, BEAT_HI=2'b10) and grant index constants in shared package fifo_wr_arb_pkg.
REQ-033 SHALL implement the two-way grant logic and last-grant pointer in one sub-module, rr_arb2; the FSM and datapath reside in fifo_wr_arb.

Verification
REQ-034 SHALL cover a narrow REQ1: REQ1_DATA=8'hA5, FIFO_FULL=0 -> REQ1_RDY in cycle 0, WR_INC=1 with WR_DATA=8'hA5 in cycle 1, BUSY=0 in cycle 2.
REQ-035 SHALL cover a wide REQ0: REQ0_DATA=16'h1234 -> WR_DATA 8'h34 then 8'h12 on consecutive WR_INC cycles.
REQ-036 SHALL cover backpressure: FIFO_FULL=1 for 3 cycles during BEAT_HI of 16'hBEEF -> WR_INC=0 and WR_DATA=8'hBE held, then a single write of 8'hBE.
REQ-037 SHALL cover a tie: both VLD held high for 4 transfers -> grants 0,1,0,1 (round-robin), and 0,0,0,0 with FIFO_WR_ARB_PRIO_EN.
REQ-038 SHALL cover mid-operation reset: RST=1 in BEAT_LO of 16'hCAFE -> next cycle IDLE, WR_INC=0, no 8'hCA written.
